// File: rtl/measure_pkg.sv
// rtl/measure_pkg.sv - shared encodings and width helpers for the cursor measurement engine
// Contents: measurement mode encoding, FSM state encoding, MUL_BITS and channel-select width helpers.
package measure_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_PKPK = 2'd1,
    MODE_TIME = 2'd2,
    MODE_FREQ = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIFF = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // One extra bit so (max field value + 1) is representable as a multiplier.
  function automatic int mul_bits(input int scale_w, input int rate_w);
    return ((scale_w > rate_w) ? scale_w : rate_w) + 1;
  endfunction

  function automatic int ch_bits(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - restoring serial divider, one quotient bit per clock
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture dividend/divisor and start; steps follow on the next DIVIDEND_W clocks
//   dividend   : numerator
//   divisor    : denominator (0 yields an all-ones quotient; callers flag that case themselves)
//   quotient   : result, stable once the final step has executed
//   last       : high during the cycle whose clock edge performs the final step
module serial_divider #(
  parameter int DIVIDEND_W = 14,
  parameter int DIVISOR_W  = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic                  last
);
  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  logic                  active;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] q_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W:0]    rem_sh;
  logic [DIVISOR_W-1:0]  rem_sub;
  logic                  take;

  // Dividend bits shift out of the top of q_q into the partial remainder while
  // quotient bits shift in at the bottom, so q_q ends up holding the quotient.
  always_comb begin
    rem_sh  = {rem_q, q_q[DIVIDEND_W-1]};
    take    = (rem_sh >= {1'b0, dvs_q});
    rem_sub = DIVISOR_W'(rem_sh - {1'b0, dvs_q});
  end

  assign last     = active && (cnt == CNT_W'(DIVIDEND_W - 1));
  assign quotient = q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
      q_q    <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (load) begin
      active <= 1'b1;
      cnt    <= '0;
      q_q    <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
    end else if (active) begin
      rem_q <= take ? rem_sub : rem_sh[DIVISOR_W-1:0];
      q_q   <= {q_q[DIVIDEND_W-2:0], take};
      cnt   <= cnt + CNT_W'(1);
      if (last) active <= 1'b0;
    end
  end

endmodule

// File: rtl/cursor_measure.sv
// rtl/cursor_measure.sv - cursor-based waveform measurement engine (pk-pk, delta-time, frequency)
// Optional feature macro: MEASURE_FREQ_EN (mode 3 frequency via serial_divider; otherwise mode 3 yields 0)
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : measurement request, accepted only when idle
//   chSel, mode       : channel and measurement select (0 none, 1 pk-pk, 2 delta-x, 3 frequency)
//   cursorx1/x2/y1/y2 : cursor coordinates
//   shiftDown         : per-channel vertical shrink, ch0 in LSBs
//   sampleAdjust      : per-channel sample-rate adjust, ch0 in LSBs
//   busy              : measurement in progress
//   valid             : one-cycle strobe when num/overflow update
//   num, overflow     : saturated result and saturation flag, held between strobes
module cursor_measure
  import measure_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CURSOR_W = 11,
  parameter int SCALE_W  = 4,
  parameter int RATE_W   = 6,
  parameter int RESULT_W = 14,
  parameter int FREQ_K   = 10000,
  localparam int CH_W    = ch_bits(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [CH_W-1:0]            chSel,
  input  logic [1:0]                 mode,
  input  logic [CURSOR_W-1:0]        cursorx1,
  input  logic [CURSOR_W-1:0]        cursorx2,
  input  logic [CURSOR_W-1:0]        cursory1,
  input  logic [CURSOR_W-1:0]        cursory2,
  input  logic [NUM_CH*SCALE_W-1:0]  shiftDown,
  input  logic [NUM_CH*RATE_W-1:0]   sampleAdjust,
  output logic                       busy,
  output logic                       valid,
  output logic [RESULT_W-1:0]        num,
  output logic                       overflow
);
  localparam int MUL_BITS = mul_bits(SCALE_W, RATE_W);
  localparam int PROD_W   = CURSOR_W + MUL_BITS;
  localparam int K_W      = $clog2(FREQ_K + 1);
  // Final value must hold the doubled product, a value just above the result
  // range, and a full frequency quotient without wrapping before saturation.
  localparam int FIN_A    = (PROD_W + 1 > RESULT_W + 1) ? PROD_W + 1 : RESULT_W + 1;
  localparam int FIN_W    = (FIN_A > K_W) ? FIN_A : K_W;
  localparam int CNT_W    = $clog2(MUL_BITS);
  localparam logic [FIN_W-1:0] RES_MAX = FIN_W'({RESULT_W{1'b1}});

  state_t state, state_nxt;

  logic [CURSOR_W-1:0] x1_q, x2_q, y1_q, y2_q;
  mode_t               mode_q;
  logic                ch_ok_q;
  logic [SCALE_W-1:0]  shrink_q;
  logic [RATE_W-1:0]   rate_q;

  logic [SCALE_W-1:0]  sel_shrink;
  logic [RATE_W-1:0]   sel_rate;
  logic                ch_ok;

  logic [CURSOR_W-1:0] opa, opb, diff;
  logic [MUL_BITS-1:0] mult_init;
  logic [PROD_W-1:0]   mcand_q, acc_q, acc_step;
  logic [MUL_BITS-1:0] mult_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mul_last;

  logic [FIN_W-1:0]    fin;
  logic                force_sat;
  logic                sat;

  // Out-of-range channels select zero settings; their result is forced to 0 later.
  always_comb begin
    sel_shrink = '0;
    sel_rate   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chSel == CH_W'(i)) begin
        sel_shrink = shiftDown[i*SCALE_W +: SCALE_W];
        sel_rate   = sampleAdjust[i*RATE_W +: RATE_W];
      end
    end
  end

  assign ch_ok = (int'(chSel) < NUM_CH);

  always_comb begin
    opa       = (mode_q == MODE_PKPK) ? y1_q : x1_q;
    opb       = (mode_q == MODE_PKPK) ? y2_q : x2_q;
    diff      = (opa >= opb) ? (opa - opb) : (opb - opa);
    mult_init = (mode_q == MODE_PKPK) ? (MUL_BITS'(shrink_q) + MUL_BITS'(1))
                                      : (MUL_BITS'(rate_q) + MUL_BITS'(1));
    acc_step  = mult_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  assign mul_last = (cnt_q == CNT_W'(MUL_BITS - 1));

`ifdef MEASURE_FREQ_EN
  logic [RESULT_W-1:0] quot;
  logic                div_last;
  logic                div_load;

  // Divisor is the product being completed on this same edge, hence acc_step.
  assign div_load = (state == S_MUL) && mul_last && (mode_q == MODE_FREQ) && ch_ok_q;

  serial_divider #(
    .DIVIDEND_W (RESULT_W),
    .DIVISOR_W  (PROD_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .dividend (RESULT_W'(FREQ_K)),
    .divisor  (acc_step),
    .quotient (quot),
    .last     (div_last)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_DIFF;
      end
      S_DIFF: state_nxt = S_MUL;
      S_MUL: begin
        if (mul_last) begin
`ifdef MEASURE_FREQ_EN
          state_nxt = ((mode_q == MODE_FREQ) && ch_ok_q) ? S_DIV : S_DONE;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef MEASURE_FREQ_EN
      S_DIV: if (div_last) state_nxt = S_DONE;
`endif
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q     <= '0;
      x2_q     <= '0;
      y1_q     <= '0;
      y2_q     <= '0;
      mode_q   <= MODE_NONE;
      ch_ok_q  <= 1'b0;
      shrink_q <= '0;
      rate_q   <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mult_q   <= '0;
      cnt_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x1_q     <= cursorx1;
            x2_q     <= cursorx2;
            y1_q     <= cursory1;
            y2_q     <= cursory2;
            mode_q   <= mode_t'(mode);
            ch_ok_q  <= ch_ok;
            shrink_q <= sel_shrink;
            rate_q   <= sel_rate;
          end
        end
        S_DIFF: begin
          mcand_q <= PROD_W'(diff);
          mult_q  <= mult_init;
          acc_q   <= '0;
          cnt_q   <= '0;
        end
        S_MUL: begin
          acc_q   <= acc_step;
          mcand_q <= mcand_q << 1;
          mult_q  <= mult_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fin       = '0;
    force_sat = 1'b0;
    if (ch_ok_q) begin
      case (mode_q)
        MODE_PKPK: fin = FIN_W'(acc_q) << 1;
        MODE_TIME: fin = FIN_W'(acc_q);
`ifdef MEASURE_FREQ_EN
        MODE_FREQ: begin
          if (acc_q == '0) force_sat = 1'b1;
          else             fin = FIN_W'(quot);
        end
`endif
        default: fin = '0;
      endcase
    end
    sat = force_sat || (fin > RES_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      num      <= '0;
      overflow <= 1'b0;
    end else begin
      valid <= (state == S_DONE);
      if (state == S_DONE) begin
        num      <= sat ? {RESULT_W{1'b1}} : fin[RESULT_W-1:0];
        overflow <= sat;
      end
    end
  end

endmodule

// File: tb/tb_cursor_measure.sv
// tb/tb_cursor_measure.sv - scoreboard bench for cursor_measure (build with/without MEASURE_FREQ_EN)
module tb_cursor_measure;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [0:0]  chSel = '0;
  logic [1:0]  mode = '0;
  logic [10:0] cursorx1 = '0, cursorx2 = '0, cursory1 = '0, cursory2 = '0;
  logic [7:0]  shiftDown = '0;
  logic [11:0] sampleAdjust = '0;
  logic        busy, valid, overflow;
  logic [13:0] num;

  cursor_measure dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .chSel        (chSel),
    .mode         (mode),
    .cursorx1     (cursorx1),
    .cursorx2     (cursorx2),
    .cursory1     (cursory1),
    .cursory2     (cursory2),
    .shiftDown    (shiftDown),
    .sampleAdjust (sampleAdjust),
    .busy         (busy),
    .valid        (valid),
    .num          (num),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    num;
    int    ov;
    int    acc;
    int    lat;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_num"}, int'(num), mon_e.num);
        check({mon_e.name, "_ovf"}, int'(overflow), mon_e.ov);
        check({mon_e.name, "_lat"}, cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  task automatic push(input string name, input int en, input int eov, input int acc, input int lat);
    exp_t e;
    e.name = name;
    e.num  = en;
    e.ov   = eov;
    e.acc  = acc;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic fire(input string name, input int en, input int eov, input int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_accepted"}, int'(busy), 1);
    push(name, en, eov, cyc, lat);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, int'(n < 200), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
`ifdef MEASURE_FREQ_EN
    localparam int LAT3 = 23;
`else
    localparam int LAT3 = 9;
`endif
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_num", int'(num), 0);
    check("rst_ovf", int'(overflow), 0);

    // pk-pk, first start accepted on first edge after reset release
    mode = 2'd1; chSel = 1'b0; shiftDown = {4'd7, 4'd3};
    cursory1 = 11'd300; cursory2 = 11'd100;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    fire("pkpk", 1600, 0, 9);
    drain("pkpk");

    // reversed cursors, start pulse while busy ignored
    cursory1 = 11'd100; cursory2 = 11'd300;
    fire("pkpk_rev", 1600, 0, 9);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain("pkpk_rev");
    repeat (3) @(posedge clk);
    #1;
    check("hold_num", int'(num), 1600);
    check("hold_valid", int'(valid), 0);

    // delta-x on ch1, inputs disturbed mid-measurement
    mode = 2'd2; chSel = 1'b1; sampleAdjust = {6'd5, 6'd9};
    cursorx1 = 11'd10; cursorx2 = 11'd650;
    fire("dx_ch1", 3840, 0, 9);
    repeat (2) @(posedge clk);
    #1;
    chSel = 1'b0; sampleAdjust = {6'd1, 6'd1}; shiftDown = 8'hFF;
    cursorx2 = 11'd20; mode = 2'd1;
    drain("dx_ch1");

    // saturation
    mode = 2'd1; chSel = 1'b0; shiftDown = {4'd0, 4'd15};
    cursory1 = 11'd2047; cursory2 = 11'd0;
    fire("sat", 16383, 1, 9);
    drain("sat");

    // reset during MUL, nothing may follow
    mode = 2'd2; sampleAdjust = {6'd0, 6'd3}; cursorx1 = 11'd0; cursorx2 = 11'd100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_num", int'(num), 0);
    check("midrst_ovf", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // mode 0
    mode = 2'd0; cursory1 = 11'd300; cursory2 = 11'd100; shiftDown = {4'd0, 4'd3};
    fire("mode0", 0, 0, 9);
    drain("mode0");

    // back-to-back with start held high
    mode = 2'd2; chSel = 1'b0; sampleAdjust = {6'd0, 6'd2};
    cursorx1 = 11'd0; cursorx2 = 11'd100;
    start = 1'b1;
    @(posedge clk); #1;
    push("b2b_first", 300, 0, cyc, 9);
    push("b2b_second", 600, 0, cyc + 10, 9);
    cursorx2 = 11'd200;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_reaccept", int'(busy), 1);
    drain("b2b");

    // mode 3
    mode = 2'd3; chSel = 1'b0; sampleAdjust = {6'd7, 6'd0};
    cursorx1 = 11'd0; cursorx2 = 11'd640;
`ifdef MEASURE_FREQ_EN
    fire("freq", 15, 0, LAT3);
    drain("freq");
    cursorx1 = 11'd5; cursorx2 = 11'd5;
    fire("freq_div0", 16383, 1, LAT3);
    drain("freq_div0");
`else
    fire("mode3_off", 0, 0, LAT3);
    drain("mode3_off");
`endif

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
